spi_byte_master: RTL and testbench
==================================

Name: spi_byte_master

Overview:
- Downstream of the 8-bit parallel-load holding register (pipo). Takes the held byte on a load strobe and serialises it MSB-first onto SPI mode 0 (CPOL=0, CPHA=0) toward the nRF radio.
- Simultaneously deserialises MISO into a received byte.
- Single-byte engine; multi-byte commands are built by issuing bytes back-to-back.

Parameters:
- CLKS_PER_HALF_BIT, 2, i_Clk cycles per SCLK half-period; legal range >= 1; SCLK = i_Clk / (2*CLKS_PER_HALF_BIT).
- DATA_W, 8, bits per transfer; only 8 is verified.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  reset, asynchronous assert, active-low.
- i_Tx_Dv  in  1  load strobe; byte accepted when high while o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to send; normally the pipo o_Data.
- o_Tx_Ready  out  1  engine idle, can accept.
- o_Rx_Dv  out  1  one-cycle pulse; o_Rx_Byte valid.
- o_Rx_Byte  out  8  byte captured from MISO.
- o_Spi_Sclk  out  1  SPI clock, idles low.
- o_Spi_Mosi  out  1  SPI data out.
- i_Spi_Miso  in  1  SPI data in; already synchronised externally.

Behaviour:
- Reset values (i_Rst_n=0, immediate):
  - o_Spi_Sclk=0, o_Spi_Mosi=0, o_Tx_Ready=1, o_Rx_Dv=0, o_Rx_Byte=0.
  - State IDLE; counters 0; o_Spi_Csn=1 if feature enabled.
- States:
  - IDLE -> SHIFT on accept (i_Tx_Dv & o_Tx_Ready).
  - SHIFT -> IDLE after 16th SCLK edge, or SHIFT -> SHIFT if re-accepted in that same cycle.
- On accept:
  - i_Tx_Byte latched into the tx shift register.
  - Next cycle: o_Tx_Ready=0 and o_Spi_Mosi = bit7.
  - i_Tx_Byte is not sampled again until the next accept.
- Edge timing:
  - Half-bit counter runs 0..CLKS_PER_HALF_BIT-1. At terminal count SCLK toggles; 16 toggles total.
  - Rising edges at accept + (2k+1)*H cycles, k=0..7, where H=CLKS_PER_HALF_BIT.
  - Each rising-edge cycle: i_Spi_Miso shifted into the rx register LSB, so the first bit received ends up as bit7.
  - Each falling edge except the 8th: o_Spi_Mosi advances to the next lower bit.
  - MOSI is therefore stable for H cycles before and after every rising edge.
- Completion, at the 8th falling edge (accept + 16*H cycles), all in that cycle:
  - o_Rx_Dv=1 for exactly one cycle.
  - o_Rx_Byte updated and held until the next completion.
  - o_Tx_Ready=1.
  - o_Spi_Mosi holds bit0 until the next accept.
- Back-to-back: i_Tx_Dv high in the completion cycle is accepted, with no idle SCLK gap beyond the normal H low time.
- i_Tx_Dv while o_Tx_Ready=0: ignored, no queuing, no error flag.
- Reset mid-transfer: immediate abort to reset values; no o_Rx_Dv for the partial byte.
- Width: bit counter 3 bits, half-bit counter $clog2(CLKS_PER_HALF_BIT)+1 bits; no wrap beyond its terminal count.

Optional Feature:
- SPI_CSN_AUTO_EN defined:
  - Adds output port o_Spi_Csn (1 bit, reset 1).
  - Goes 0 in the cycle after accept, together with MOSI bit7.
  - Stays 0 through a back-to-back accept.
  - Returns to 1 one cycle after a completion cycle that had no new accept.
- Not defined: port absent; chip-select is driven by the controller outside this block.

Decomposition:
- Shared include spi_defs.vh: state localparams (IDLE, SHIFT), SPI mode constant, default CLKS_PER_HALF_BIT.
- One natural sub-module: spi_clk_gen.
  - Half-bit counter plus edge counter.
  - Emits o_Rise_Stb, o_Fall_Stb, o_Last_Stb and drives SCLK.
  - Parent holds the state, shift registers and handshake.

Test Plan:
- Reset release -> o_Tx_Ready=1, o_Spi_Sclk=0, o_Rx_Dv=0, o_Rx_Byte=0x00, with no SCLK activity for 50 cycles.
- H=2; i_Tx_Byte=0xAC, i_Tx_Dv for 1 cycle, MISO loops back from MOSI -> MOSI bits 1,0,1,0,1,1,0,0 on the rising edges; o_Rx_Dv at accept+32 cycles; o_Rx_Byte=0xAC.
- H=2; i_Tx_Byte=0xAA, MISO driven with 0x5A (independent bits) -> o_Rx_Byte=0x5A; 8 rising edges counted; SCLK period exactly 4 cycles.
- Back-to-back: 0x20 then 0x0F, with second i_Tx_Dv in the completion cycle -> 16 contiguous SCLK pulses, two o_Rx_Dv pulses 32 cycles apart; with SPI_CSN_AUTO_EN, o_Spi_Csn low continuously across both bytes.
- i_Tx_Dv with 0xFF at accept+5 during a 0xAC transfer -> ignored; MOSI sequence unchanged; exactly one o_Rx_Dv.
- i_Rst_n low at the 4th SCLK rising edge -> SCLK low immediately, o_Tx_Ready=1, no o_Rx_Dv; a following 0x55 transfer completes correctly.

Source files
------------

// File: rtl/spi_byte_master_pkg.sv
// Shared definitions for the SPI byte master: FSM states, SPI mode and
// the default SCLK divider.
package spi_byte_master_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Mode 0: CPOL=0 (SCLK idles low), CPHA=0 (sample on rising edge)
  localparam int SPI_MODE              = 0;
  localparam int DEF_CLKS_PER_HALF_BIT = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-bit counter plus bit (edge-pair) counter. Emits
// strobes in the cycle before each SCLK edge so the parent can act on the
// same clock edge that moves SCLK.
import spi_byte_master_pkg::*;

module spi_clk_gen #(
  parameter int CLKS_PER_HALF_BIT = DEF_CLKS_PER_HALF_BIT,
  parameter int BITS              = 8
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_En,
  input  logic i_Start,
  output logic o_Rise_Stb,
  output logic o_Fall_Stb,
  output logic o_Last_Stb,
  output logic o_Sclk
);

  localparam int HW = $clog2(CLKS_PER_HALF_BIT) + 1;
  localparam int BW = $clog2(BITS);

  logic [HW-1:0] r_half;
  logic [BW-1:0] r_bit;
  logic          r_sclk;
  logic          w_tc;

  assign w_tc       = i_En & (r_half == HW'(CLKS_PER_HALF_BIT - 1));
  assign o_Rise_Stb = w_tc & ~r_sclk;
  assign o_Fall_Stb = w_tc &  r_sclk;
  assign o_Last_Stb = o_Fall_Stb & (r_bit == BW'(BITS - 1));
  assign o_Sclk     = r_sclk;

  // Counters restart on every accept (incl. back-to-back) and rest at zero when idle
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_half <= '0;
      r_bit  <= '0;
      r_sclk <= 1'b0;
    end else if (i_Start || !i_En) begin
      r_half <= '0;
      r_bit  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tc) begin
      r_half <= '0;
      r_sclk <= ~r_sclk;
      if (r_sclk) r_bit <= r_bit + 1'b1;
    end else begin
      r_half <= r_half + 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Single-byte SPI mode-0 master, MSB first, full duplex.
// Optional macro SPI_CSN_AUTO_EN adds an auto-managed active-low o_Spi_Csn.
// Completion (o_Rx_Dv, o_Tx_Ready) is flagged in the cycle of the final
// falling-edge strobe so a new byte can follow with no extra SCLK gap.
import spi_byte_master_pkg::*;

module spi_byte_master #(
  parameter int CLKS_PER_HALF_BIT = DEF_CLKS_PER_HALF_BIT,
  parameter int DATA_W            = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Tx_Dv,
  input  logic [DATA_W-1:0] i_Tx_Byte,
  output logic              o_Tx_Ready,
  output logic              o_Rx_Dv,
  output logic [DATA_W-1:0] o_Rx_Byte,
  output logic              o_Spi_Sclk,
  output logic              o_Spi_Mosi,
  input  logic              i_Spi_Miso
`ifdef SPI_CSN_AUTO_EN
  ,
  output logic              o_Spi_Csn
`endif
);

  state_t            r_state, w_state_nxt;
  logic              w_en, w_ready, w_accept;
  logic              w_rise, w_fall, w_last;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_hold;

  spi_clk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
    .BITS             (DATA_W)
  ) u_clk_gen (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_En      (w_en),
    .i_Start   (w_accept),
    .o_Rise_Stb(w_rise),
    .o_Fall_Stb(w_fall),
    .o_Last_Stb(w_last),
    .o_Sclk    (o_Spi_Sclk)
  );

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and handshake; ready also in the completion cycle
  always_comb begin
    w_state_nxt = r_state;
    w_en        = (r_state == ST_SHIFT);
    w_ready     = ~w_en | w_last;
    w_accept    = i_Tx_Dv & w_ready;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last && !w_accept) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // TX shifter: load on accept, advance on every falling edge but the last
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                r_tx <= '0;
    else if (w_accept)           r_tx <= i_Tx_Byte;
    else if (w_fall && !w_last)  r_tx <= {r_tx[DATA_W-2:0], 1'b0};
  end

  // RX shifter samples MISO on rising edges; holding copy taken at completion
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_rx      <= '0;
      r_rx_hold <= '0;
    end else begin
      if (w_rise) r_rx      <= {r_rx[DATA_W-2:0], i_Spi_Miso};
      if (w_last) r_rx_hold <= r_rx;
    end
  end

  assign o_Tx_Ready = w_ready;
  assign o_Rx_Dv    = w_last;
  assign o_Rx_Byte  = w_last ? r_rx : r_rx_hold;
  assign o_Spi_Mosi = r_tx[DATA_W-1];

`ifdef SPI_CSN_AUTO_EN
  logic r_csn;

  // Chip select: low from accept, released after a completion with no follow-on byte
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)      r_csn <= 1'b1;
    else if (w_accept) r_csn <= 1'b0;
    else if (w_last)   r_csn <= 1'b1;
  end

  assign o_Spi_Csn = r_csn;
`endif

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master with CLKS_PER_HALF_BIT=2.
module tb_spi_byte_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       sclk;
  logic       mosi;
  logic       miso;
`ifdef SPI_CSN_AUTO_EN
  logic       csn;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_byte_master #(.CLKS_PER_HALF_BIT(2), .DATA_W(8)) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Tx_Dv   (tx_dv),
    .i_Tx_Byte (tx_byte),
    .o_Tx_Ready(tx_ready),
    .o_Rx_Dv   (rx_dv),
    .o_Rx_Byte (rx_byte),
    .o_Spi_Sclk(sclk),
    .o_Spi_Mosi(mosi),
    .i_Spi_Miso(miso)
`ifdef SPI_CSN_AUTO_EN
    ,
    .o_Spi_Csn (csn)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one byte and watch ncyc cycles after the accept edge. Cycle n is the
  // cycle ending at the n-th clock edge after accept; sampled on its negedge.
  // Optionally raise i_Tx_Dv again during cycle inj_at with inj_byte.
  task automatic xfer(input logic [7:0] tx, input bit loopb, input logic [15:0] mpat,
                      input int ncyc, input int inj_at, input logic [7:0] inj_byte,
                      output logic [15:0] mbits, output int rises, output int dvs,
                      output int dv0, output int dv1, output logic [7:0] rx0,
                      output logic [7:0] rx1, output int minper, output int maxper);
    logic prev;
    int   last_rise;
    mbits = '0; rises = 0; dvs = 0; dv0 = -1; dv1 = -1; rx0 = '0; rx1 = '0;
    minper = 1000; maxper = 0; last_rise = 0; prev = 1'b0;
    @(negedge clk);
    tx_byte = tx; tx_dv = 1'b1;
    miso = loopb ? tx[7] : mpat[15];
    @(posedge clk); #1;
    tx_dv = 1'b0; tx_byte = ~tx;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (sclk && !prev) begin
        rises++;
        mbits = {mbits[14:0], mosi};
        if (last_rise > 0) begin
          if (n - last_rise < minper) minper = n - last_rise;
          if (n - last_rise > maxper) maxper = n - last_rise;
        end
        last_rise = n;
      end
      prev = sclk;
      if (rx_dv) begin
        dvs++;
        if (dvs == 1) begin dv0 = n; rx0 = rx_byte; end
        if (dvs == 2) begin dv1 = n; rx1 = rx_byte; end
      end
      if (loopb) miso = mosi;
      else if (rises < 16) miso = mpat[15 - rises];
      if (n == inj_at + 1) tx_dv = 1'b0;
      if (n == inj_at) begin tx_dv = 1'b1; tx_byte = inj_byte; end
    end
    tx_dv = 1'b0;
  endtask

  initial begin : stim
    logic [15:0] mb;
    int          r, d, d0, d1, mnp, mxp, hi, cnt;
    logic [7:0]  x0, x1;
    logic        prv;

    rst_n = 1'b0; tx_dv = 1'b0; tx_byte = 8'h00; miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rx_dv", rx_dv, 0);
    chk("post_rst_rx_byte", rx_byte, 8'h00);
    hi = 0; cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sclk) hi++;
      if (rx_dv) cnt++;
    end
    chk("idle_sclk_activity", hi, 0);
    chk("idle_rx_dv", cnt, 0);

    // 0xAC with MISO looped back from MOSI
    xfer(8'hAC, 1'b1, 16'h0, 40, -10, 8'h00, mb, r, d, d0, d1, x0, x1, mnp, mxp);
    chk("ac_mosi_bits", mb[7:0], 8'hAC);
    chk("ac_rises", r, 8);
    chk("ac_dv_count", d, 1);
    chk("ac_dv_cycle", d0, 32);
    chk("ac_rx_byte", x0, 8'hAC);
    chk("ac_ready_after", tx_ready, 1);
    chk("ac_rx_hold", rx_byte, 8'hAC);
    chk("ac_mosi_holds_bit0", mosi, 0);

    // 0xAA out, independent 0x5A in
    xfer(8'hAA, 1'b0, 16'h5A00, 40, -10, 8'h00, mb, r, d, d0, d1, x0, x1, mnp, mxp);
    chk("aa_mosi_bits", mb[7:0], 8'hAA);
    chk("aa_rises", r, 8);
    chk("aa_rx_byte", x0, 8'h5A);
    chk("aa_dv_cycle", d0, 32);
    chk("aa_min_period", mnp, 4);
    chk("aa_max_period", mxp, 4);

    // Back-to-back 0x20 then 0x0F, second strobe in the completion cycle
    xfer(8'h20, 1'b1, 16'h0, 72, 32, 8'h0F, mb, r, d, d0, d1, x0, x1, mnp, mxp);
    chk("b2b_rises", r, 16);
    chk("b2b_mosi_bits", mb, 16'h200F);
    chk("b2b_min_period", mnp, 4);
    chk("b2b_max_period", mxp, 4);
    chk("b2b_dv_count", d, 2);
    chk("b2b_dv_first", d0, 32);
    chk("b2b_dv_spacing", d1 - d0, 32);
    chk("b2b_rx0", x0, 8'h20);
    chk("b2b_rx1", x1, 8'h0F);
    chk("b2b_rx_hold", rx_byte, 8'h0F);

    // Strobe with 0xFF while busy must be ignored
    xfer(8'hAC, 1'b1, 16'h0, 44, 5, 8'hFF, mb, r, d, d0, d1, x0, x1, mnp, mxp);
    chk("busy_mosi_bits", mb[7:0], 8'hAC);
    chk("busy_rises", r, 8);
    chk("busy_dv_count", d, 1);
    chk("busy_rx_byte", x0, 8'hAC);

    // Reset asserted right after the 4th SCLK rising edge
    @(negedge clk);
    tx_byte = 8'hAC; tx_dv = 1'b1;
    @(posedge clk); #1;
    tx_dv = 1'b0;
    r = 0; prv = 1'b0;
    for (int n = 1; n <= 40 && r < 4; n++) begin
      @(negedge clk);
      if (sclk && !prv) r++;
      prv = sclk;
      miso = mosi;
    end
    chk("mid_rst_reached_rise4", r, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_rx_dv", rx_dv, 0);
    chk("mid_rst_rx_byte", rx_byte, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi = 0; cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sclk) hi++;
      if (rx_dv) cnt++;
    end
    chk("after_abort_sclk", hi, 0);
    chk("after_abort_rx_dv", cnt, 0);

    xfer(8'h55, 1'b1, 16'h0, 40, -10, 8'h00, mb, r, d, d0, d1, x0, x1, mnp, mxp);
    chk("x55_mosi_bits", mb[7:0], 8'h55);
    chk("x55_dv_count", d, 1);
    chk("x55_dv_cycle", d0, 32);
    chk("x55_rx_byte", x0, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
